// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS32 decode constants, select enums and the decoded-bundle type
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_RA   = 2'd2,
    DST_RSVD = 2'd3
  } reg_dst_e;

  typedef enum logic [1:0] {
    EXT_SIGN     = 2'd0,
    EXT_ZERO     = 2'd1,
    EXT_UPPER    = 2'd2,
    EXT_SIGN_ALT = 2'd3
  } ext_mode_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rreg_a;
    logic [4:0]  rreg_b;
    logic [4:0]  wreg;
    logic [31:0] imme_num;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic        jmp_reg;
    logic        jmp_imm;
    logic        is_branch;
    logic        link;
  } id_bundle_t;

  // An empty slot must never present a stale jump/branch/link to EX.
  function automatic id_bundle_t clear_flags(input id_bundle_t b);
    id_bundle_t r;
    r           = b;
    r.jmp_reg   = 1'b0;
    r.jmp_imm   = 1'b0;
    r.is_branch = 1'b0;
    r.link      = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - IF-side and EX-side handshake plus decoded fields of the decode stage
interface id_stage_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic [1:0]      reg_dst;
  logic [1:0]      ext_mode;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [5:0]      opcode;
  logic [4:0]      rreg_a;
  logic [4:0]      rreg_b;
  logic [4:0]      wreg;
  logic [31:0]     imme_num;
  logic [5:0]      func;
  logic [4:0]      shamt;
  logic            jmp_reg;
  logic            jmp_imm;
  logic            is_branch;
  logic            link;
  logic [PC_W-1:0] link_pc;
  logic [PC_W-1:0] out_pc;

  modport master (
    output in_valid, in_inst, in_pc, reg_dst, ext_mode, flush, out_ready,
    input  in_ready, out_valid, opcode, rreg_a, rreg_b, wreg, imme_num, func, shamt,
           jmp_reg, jmp_imm, is_branch, link, link_pc, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, reg_dst, ext_mode, flush, out_ready,
    output in_ready, out_valid, opcode, rreg_a, rreg_b, wreg, imme_num, func, shamt,
           jmp_reg, jmp_imm, is_branch, link, link_pc, out_pc
  );
endinterface

// File: rtl/id_decode_comb.sv
// rtl/id_decode_comb.sv - combinational MIPS32 field split, destination select, immediate extend and jump flags
module id_decode_comb
  import mips_pkg::*;
#(
  parameter int unsigned RA_IDX  = 31,
  parameter bit          JALR_EN = 1'b1
) (
  input  logic [31:0] inst_i,
  input  logic [1:0]  reg_dst_i,
  input  logic [1:0]  ext_mode_i,
  output id_bundle_t  bundle_o
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        is_jal;
  logic        is_jalr;

  assign op      = inst_i[31:26];
  assign fn      = inst_i[5:0];
  assign rt      = inst_i[20:16];
  assign rd      = inst_i[15:11];
  assign imm     = inst_i[15:0];
  assign is_jal  = (op == OP_JAL);
  assign is_jalr = JALR_EN && (op == OP_SPECIAL) && (fn == FN_JALR);

  always_comb begin
    bundle_o        = '0;
    bundle_o.opcode = op;
    bundle_o.rreg_a = inst_i[25:21];
    bundle_o.rreg_b = rt;
    bundle_o.func   = fn;
    bundle_o.shamt  = inst_i[10:6];

    // Link instructions override the caller's destination choice when they must write $ra.
    if (is_jal || (is_jalr && rd == 5'd0)) begin
      bundle_o.wreg = 5'(RA_IDX);
    end else begin
      case (reg_dst_e'(reg_dst_i))
        DST_RD:  bundle_o.wreg = rd;
        DST_RA:  bundle_o.wreg = 5'(RA_IDX);
        default: bundle_o.wreg = rt;
      endcase
    end

    case (ext_mode_e'(ext_mode_i))
      EXT_ZERO:  bundle_o.imme_num = {16'h0000, imm};
      EXT_UPPER: bundle_o.imme_num = {imm, 16'h0000};
      default:   bundle_o.imme_num = {{16{imm[15]}}, imm};
    endcase

    bundle_o.jmp_reg   = (op == OP_SPECIAL) && ((fn == FN_JR) || is_jalr);
    bundle_o.jmp_imm   = (op == OP_J) || is_jal;
    bundle_o.is_branch = (op inside {OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ});
    bundle_o.link      = is_jal || is_jalr;
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - registered decode stage: one output slot behind a valid/ready handshake with flush
module id_stage
  import mips_pkg::*;
#(
  parameter int          PC_W    = 32,
  parameter int unsigned RA_IDX  = 31,
  parameter bit          JALR_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  id_bundle_t      dec;
  id_bundle_t      bundle_q, bundle_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] link_pc_q, link_pc_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic            accept;

  id_decode_comb #(
    .RA_IDX  (RA_IDX),
    .JALR_EN (JALR_EN)
  ) u_decode (
    .inst_i     (bus.in_inst),
    .reg_dst_i  (bus.reg_dst),
    .ext_mode_i (bus.ext_mode),
    .bundle_o   (dec)
  );

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Flush still lets IF see its handshake complete; the accepted word is simply dropped.
  always_comb begin
    valid_d   = valid_q;
    bundle_d  = bundle_q;
    link_pc_d = link_pc_q;
    out_pc_d  = out_pc_q;
    if (bus.flush) begin
      valid_d  = 1'b0;
      bundle_d = clear_flags(bundle_q);
    end else if (accept) begin
      valid_d   = 1'b1;
      bundle_d  = dec;
      link_pc_d = bus.in_pc + PC_W'(8);
      out_pc_d  = bus.in_pc;
    end else if (bus.out_ready) begin
      valid_d  = 1'b0;
      bundle_d = clear_flags(bundle_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      bundle_q  <= '0;
      link_pc_q <= '0;
      out_pc_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      bundle_q  <= bundle_d;
      link_pc_q <= link_pc_d;
      out_pc_q  <= out_pc_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.opcode    = bundle_q.opcode;
  assign bus.rreg_a    = bundle_q.rreg_a;
  assign bus.rreg_b    = bundle_q.rreg_b;
  assign bus.wreg      = bundle_q.wreg;
  assign bus.imme_num  = bundle_q.imme_num;
  assign bus.func      = bundle_q.func;
  assign bus.shamt     = bundle_q.shamt;
  assign bus.jmp_reg   = bundle_q.jmp_reg;
  assign bus.jmp_imm   = bundle_q.jmp_imm;
  assign bus.is_branch = bundle_q.is_branch;
  assign bus.link      = bundle_q.link;
  assign bus.link_pc   = link_pc_q;
  assign bus.out_pc    = out_pc_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed and randomized checks of id_stage against a behavioural decode model
module tb_id_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_if #(.PC_W(32)) bus_en ();
  id_stage_if #(.PC_W(32)) bus_nj ();

  id_stage #(.PC_W(32), .RA_IDX(31), .JALR_EN(1'b1)) u_dut_en (.clk(clk), .rst(rst), .bus(bus_en));
  id_stage #(.PC_W(32), .RA_IDX(31), .JALR_EN(1'b0)) u_dut_nj (.clk(clk), .rst(rst), .bus(bus_nj));

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural slot model
  bit          m_valid;
  bit          m_after_reset;
  bit          m_flags_zero;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  int          m_rd;
  int          m_ext;

  typedef logic [31:0] vec13_t [13];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  // Expected fields in output order: opcode rs rt wreg imm func shamt jr jimm br link link_pc pc
  function automatic vec13_t model_decode(input logic [31:0] inst, input logic [31:0] pc,
                                          input int rd_sel, input int ext, input bit jalr_en);
    vec13_t e;
    int unsigned w, op, rs, rt, rd, sh, fn, imm;
    bit is_jalr;
    w   = inst;
    op  = w / (1 << 26);
    rs  = (w / (1 << 21)) % 32;
    rt  = (w / (1 << 16)) % 32;
    rd  = (w / (1 << 11)) % 32;
    sh  = (w / (1 << 6)) % 32;
    fn  = w % 64;
    imm = w % 65536;
    is_jalr = jalr_en && op == 0 && fn == 9;
    e[0] = op; e[1] = rs; e[2] = rt; e[5] = fn; e[6] = sh;
    if (op == 3 || (is_jalr && rd == 0)) e[3] = 31;
    else if (rd_sel == 1)                e[3] = rd;
    else if (rd_sel == 2)                e[3] = 31;
    else                                 e[3] = rt;
    if (ext == 1)          e[4] = imm;
    else if (ext == 2)     e[4] = imm * 65536;
    else if (imm >= 32768) e[4] = imm + 32'hFFFF0000;
    else                   e[4] = imm;
    e[7]  = (op == 0 && (fn == 8 || is_jalr)) ? 1 : 0;
    e[8]  = (op == 2 || op == 3) ? 1 : 0;
    e[9]  = (op == 1 || (op >= 4 && op <= 7)) ? 1 : 0;
    e[10] = (op == 3 || is_jalr) ? 1 : 0;
    e[11] = 32'((longint'(pc) + 8) % (longint'(1) << 32));
    e[12] = pc;
    return e;
  endfunction

  task automatic check_dut(input int which);
    vec13_t o, e;
    string names [13] = '{"opcode", "rreg_a", "rreg_b", "wreg", "imme_num", "func", "shamt",
                          "jmp_reg", "jmp_imm", "is_branch", "link", "link_pc", "out_pc"};
    logic ov;
    if (which == 0) begin
      ov = bus_en.out_valid;
      o = '{32'(bus_en.opcode), 32'(bus_en.rreg_a), 32'(bus_en.rreg_b), 32'(bus_en.wreg),
            bus_en.imme_num, 32'(bus_en.func), 32'(bus_en.shamt), 32'(bus_en.jmp_reg),
            32'(bus_en.jmp_imm), 32'(bus_en.is_branch), 32'(bus_en.link), bus_en.link_pc, bus_en.out_pc};
    end else begin
      ov = bus_nj.out_valid;
      o = '{32'(bus_nj.opcode), 32'(bus_nj.rreg_a), 32'(bus_nj.rreg_b), 32'(bus_nj.wreg),
            bus_nj.imme_num, 32'(bus_nj.func), 32'(bus_nj.shamt), 32'(bus_nj.jmp_reg),
            32'(bus_nj.jmp_imm), 32'(bus_nj.is_branch), 32'(bus_nj.link), bus_nj.link_pc, bus_nj.out_pc};
    end
    e = model_decode(m_inst, m_pc, m_rd, m_ext, which == 0);
    chk($sformatf("d%0d_out_valid", which), 32'(ov), 32'(m_valid));
    for (int i = 0; i < 13; i++) begin
      if (m_valid)
        chk($sformatf("d%0d_%s", which, names[i]), o[i], e[i]);
      else if (m_after_reset)
        chk($sformatf("d%0d_%s_rst", which, names[i]), o[i], 32'h0);
      else if (m_flags_zero && i >= 7 && i <= 10)
        chk($sformatf("d%0d_%s_flushed", which, names[i]), o[i], 32'h0);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc, input int rd_sel,
                      input int ext, input bit ordy, input bit fl, input bit r);
    bit rdy_exp;
    @(negedge clk);
    rst = r;
    bus_en.in_valid = v;   bus_nj.in_valid = v;
    bus_en.in_inst = inst; bus_nj.in_inst = inst;
    bus_en.in_pc = pc;     bus_nj.in_pc = pc;
    bus_en.reg_dst = 2'(rd_sel);  bus_nj.reg_dst = 2'(rd_sel);
    bus_en.ext_mode = 2'(ext);    bus_nj.ext_mode = 2'(ext);
    bus_en.out_ready = ordy; bus_nj.out_ready = ordy;
    bus_en.flush = fl;     bus_nj.flush = fl;
    #1;
    rdy_exp = !m_valid || ordy;
    chk("d0_in_ready", 32'(bus_en.in_ready), 32'(rdy_exp));
    chk("d1_in_ready", 32'(bus_nj.in_ready), 32'(rdy_exp));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_after_reset = 1; m_flags_zero = 1;
    end else if (fl) begin
      m_valid = 0; m_flags_zero = 1;
    end else if (v && rdy_exp) begin
      m_valid = 1; m_after_reset = 0; m_flags_zero = 0;
      m_inst = inst; m_pc = pc; m_rd = rd_sel; m_ext = ext;
    end else if (ordy) begin
      m_valid = 0;
    end
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0: w[31:26] = 6'h00;
      1: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
      2: begin w[31:26] = 6'h00; w[5:0] = 6'h09; if ($urandom_range(0, 1) == 0) w[15:11] = 5'd0; end
      3: w[31:26] = 6'(2 + $urandom_range(0, 1));
      4: w[31:26] = 6'($urandom_range(4, 7));
      5: w[31:26] = 6'h01;
      default: ;
    endcase
    return w;
  endfunction

  logic [31:0] held_opcode;
  logic [31:0] held_pc;

  initial begin
    bus_en.in_valid = 0; bus_nj.in_valid = 0;
    bus_en.in_inst = '0; bus_nj.in_inst = '0;
    bus_en.in_pc = '0;   bus_nj.in_pc = '0;
    bus_en.reg_dst = '0; bus_nj.reg_dst = '0;
    bus_en.ext_mode = '0; bus_nj.ext_mode = '0;
    bus_en.out_ready = 0; bus_nj.out_ready = 0;
    bus_en.flush = 0;    bus_nj.flush = 0;
    m_valid = 0; m_after_reset = 1; m_flags_zero = 1;
    m_inst = '0; m_pc = '0; m_rd = 0; m_ext = 0;
    repeat (2) @(posedge clk);

    // Reset state
    step(0, 32'h0, 32'h0, 0, 0, 1, 0, 1);
    step(0, 32'h0, 32'h0, 0, 0, 1, 0, 0);

    // addi $8,$0,-1
    step(1, 32'h2008FFFF, 32'h00400000, 0, 0, 1, 0, 0);
    chk("tp_addi_valid", 32'(bus_en.out_valid), 32'd1);
    chk("tp_addi_wreg", 32'(bus_en.wreg), 32'd8);
    chk("tp_addi_imm", bus_en.imme_num, 32'hFFFFFFFF);
    chk("tp_addi_rs", 32'(bus_en.rreg_a), 32'd0);
    chk("tp_addi_link_pc", bus_en.link_pc, 32'h00400008);

    // lui-style immediate under zero and upper extend
    step(1, 32'h3C018000, 32'h00400004, 0, 1, 1, 0, 0);
    chk("tp_zext", bus_en.imme_num, 32'h00008000);
    step(1, 32'h3C018000, 32'h00400008, 0, 2, 1, 0, 0);
    chk("tp_upper", bus_en.imme_num, 32'h80000000);

    // jr, jalr with and without JALR_EN
    step(1, 32'h03E00008, 32'h0040000C, 1, 0, 1, 0, 0);
    chk("tp_jr_jmp_reg", 32'(bus_en.jmp_reg), 32'd1);
    chk("tp_jr_link", 32'(bus_en.link), 32'd0);
    step(1, 32'h0040F809, 32'h00400010, 1, 0, 1, 0, 0);
    chk("tp_jalr_jmp_reg", 32'(bus_en.jmp_reg), 32'd1);
    chk("tp_jalr_link", 32'(bus_en.link), 32'd1);
    chk("tp_jalr_wreg", 32'(bus_en.wreg), 32'd31);
    chk("tp_nojalr_jmp_reg", 32'(bus_nj.jmp_reg), 32'd0);
    chk("tp_nojalr_link", 32'(bus_nj.link), 32'd0);
    step(1, 32'h00400009, 32'h00400014, 1, 0, 1, 0, 0);
    chk("tp_jalr_rd0_wreg", 32'(bus_en.wreg), 32'd31);

    // jal overrides reg_dst; link_pc wraps
    step(1, 32'h0C100000, 32'hFFFFFFFC, 1, 0, 1, 0, 0);
    chk("tp_jal_jmp_imm", 32'(bus_en.jmp_imm), 32'd1);
    chk("tp_jal_link", 32'(bus_en.link), 32'd1);
    chk("tp_jal_wreg", 32'(bus_en.wreg), 32'd31);
    chk("tp_jal_link_pc", bus_en.link_pc, 32'h00000004);

    // Hold for 3 cycles, then drain and accept together
    step(1, 32'h8C430010, 32'h00400020, 0, 0, 1, 0, 0);
    held_opcode = 32'(bus_en.opcode);
    held_pc     = bus_en.out_pc;
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h10220005, 32'h00400100 + 32'(i * 4), 0, 0, 0, 0, 0);
      chk("tp_hold_in_ready", 32'(bus_en.in_ready), 32'd0);
      chk("tp_hold_opcode", 32'(bus_en.opcode), held_opcode);
      chk("tp_hold_pc", bus_en.out_pc, held_pc);
    end
    step(1, 32'h10220005, 32'h00400200, 0, 0, 1, 0, 0);
    chk("tp_nobubble_valid", 32'(bus_en.out_valid), 32'd1);
    chk("tp_nobubble_branch", 32'(bus_en.is_branch), 32'd1);
    chk("tp_nobubble_pc", bus_en.out_pc, 32'h00400200);

    // Flush with valid output and an offered instruction
    step(1, 32'h08000040, 32'h00400300, 0, 0, 1, 1, 0);
    chk("tp_flush_valid", 32'(bus_en.out_valid), 32'd0);
    chk("tp_flush_jmp_imm", 32'(bus_en.jmp_imm), 32'd0);
    step(0, 32'h0, 32'h0, 0, 0, 1, 0, 0);
    chk("tp_flush_dropped", 32'(bus_en.out_valid), 32'd0);

    // Reset in the middle of a hold
    step(1, 32'h0C000123, 32'h00400400, 0, 0, 1, 0, 0);
    step(1, 32'h0C000456, 32'h00400404, 0, 0, 0, 0, 0);
    step(1, 32'h0C000456, 32'h00400404, 0, 0, 0, 0, 1);
    chk("tp_rst_valid", 32'(bus_en.out_valid), 32'd0);
    chk("tp_rst_link_pc", bus_en.link_pc, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
